// File: rtl/array_prod_serial.sv
// Serial signed fixed-point dot product: one multiply-accumulate per clock,
// then a single floor-shift and saturation into Q(QN.QM).
module array_prod_serial #(
    parameter int ARRAY_SZ = 8,
    parameter int QN       = 6,
    parameter int QM       = 11,
    parameter int BITWIDTH = QN + QM + 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [ARRAY_SZ*BITWIDTH-1:0] weights,
    input  logic [ARRAY_SZ*BITWIDTH-1:0] inputs,
    output logic                         dataReady,
    output logic [BITWIDTH-1:0]          result
);

    localparam int IDX_W  = $clog2(ARRAY_SZ);
    localparam int PROD_W = 2 * BITWIDTH;
    localparam int ACC_W  = PROD_W + IDX_W;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (BITWIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(ARRAY_SZ - 1);

    typedef enum logic [1:0] {
        S_COMPUTE = 2'd0,
        S_FINISH  = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    function automatic logic [BITWIDTH-1:0] saturate(input logic signed [ACC_W-1:0] v);
        logic [BITWIDTH-1:0] s;
        if (v > SAT_MAX) begin
            s = SAT_MAX[BITWIDTH-1:0];
        end else if (v < SAT_MIN) begin
            s = SAT_MIN[BITWIDTH-1:0];
        end else begin
            s = v[BITWIDTH-1:0];
        end
        return s;
    endfunction

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic [BITWIDTH-1:0]        result_q, result_d;
    logic                       data_ready_q, data_ready_d;

    logic signed [BITWIDTH-1:0] w_s, x_s;
    logic signed [PROD_W-1:0]   prod_s;
    logic signed [ACC_W-1:0]    shifted_s;

    // Current element pair and its exact product
    always_comb begin
        w_s       = signed'(weights[idx_q*BITWIDTH +: BITWIDTH]);
        x_s       = signed'(inputs[idx_q*BITWIDTH +: BITWIDTH]);
        prod_s    = PROD_W'(w_s) * PROD_W'(x_s);
        shifted_s = acc_q >>> QM;
    end

    // Next-state and datapath control
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        result_d     = result_q;
        data_ready_d = data_ready_q;
        case (state_q)
            S_COMPUTE: begin
                acc_d = acc_q + ACC_W'(prod_s);
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = S_FINISH;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_FINISH: begin
                result_d     = saturate(shifted_s);
                data_ready_d = 1'b1;
                state_d      = S_DONE;
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                // Unreachable encoding: restart cleanly rather than lock up
                state_d      = S_COMPUTE;
                idx_d        = '0;
                acc_d        = '0;
                result_d     = '0;
                data_ready_d = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_COMPUTE;
            idx_q        <= '0;
            acc_q        <= '0;
            result_q     <= '0;
            data_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            result_q     <= result_d;
            data_ready_q <= data_ready_d;
        end
    end

    assign dataReady = data_ready_q;
    assign result    = result_q;

endmodule

// File: tb/tb_array_prod_serial.sv
// Directed bench for array_prod_serial with hand-computed expected results.
module tb_array_prod_serial;

    localparam int N  = 8;
    localparam int BW = 18;

    logic              clock;
    logic              reset;
    logic [N*BW-1:0]   weights;
    logic [N*BW-1:0]   inputs;
    logic              dataReady;
    logic [BW-1:0]     result;

    int total;
    int bad;

    array_prod_serial dut (
        .clock     (clock),
        .reset     (reset),
        .weights   (weights),
        .inputs    (inputs),
        .dataReady (dataReady),
        .result    (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_all(input logic [BW-1:0] w, input logic [BW-1:0] x);
        for (int i = 0; i < N; i++) begin
            weights[i*BW +: BW] = w;
            inputs[i*BW +: BW]  = x;
        end
    endtask

    // Pulse reset, then expect dataReady low on edges 1..8 and the result on edge 9
    task automatic run(input string tag, input logic [BW-1:0] exp);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        for (int k = 1; k <= N; k++) begin
            @(negedge clock);
            check({tag, "_ready_early"}, {31'd0, dataReady}, 32'd0);
        end
        @(negedge clock);
        check({tag, "_ready"}, {31'd0, dataReady}, 32'd1);
        check({tag, "_result"}, {14'd0, result}, {14'd0, exp});
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b0;
        weights = '0;
        inputs  = '0;

        repeat (2) @(negedge clock);
        check("reset_ready", {31'd0, dataReady}, 32'd0);
        check("reset_result", {14'd0, result}, 32'd0);

        set_all(18'h00190, 18'h00190);
        run("equal", 18'h00271);

        for (int i = 0; i < N; i++) begin
            weights[i*BW +: BW] = 18'((i + 1) * 2048);
            inputs[i*BW +: BW]  = 18'h00800;
        end
        run("ramp", 18'h12000);

        set_all(18'h3F800, 18'h00400);
        run("signed", 18'h3E000);

        set_all(18'h03800, 18'h03800);
        run("sat_pos", 18'h1FFFF);

        set_all(18'h03800, 18'h3C800);
        run("sat_neg", 18'h20000);

        set_all(18'h00000, 18'h00000);
        weights[0 +: BW] = 18'h00001;
        inputs[0 +: BW]  = 18'h00001;
        run("trunc_pos", 18'h00000);

        weights[0 +: BW] = 18'h3FFFF;
        run("trunc_neg", 18'h3FFFF);

        // Reset while holding a finished, non-zero result clears it at once
        set_all(18'h00190, 18'h00190);
        run("pre_mid", 18'h00271);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("done_rst_ready", {31'd0, dataReady}, 32'd0);
        check("done_rst_result", {14'd0, result}, 32'd0);

        // Abort after edge 4 and rerun from scratch
        @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        #1;
        check("mid_rst_ready", {31'd0, dataReady}, 32'd0);
        check("mid_rst_result", {14'd0, result}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        for (int k = 1; k <= N; k++) begin
            @(negedge clock);
            check("rerun_ready_early", {31'd0, dataReady}, 32'd0);
        end
        @(negedge clock);
        check("rerun_ready", {31'd0, dataReady}, 32'd1);
        check("rerun_result", {14'd0, result}, 32'h00271);

        // Held in DONE while inputs wander
        for (int c = 0; c < 24; c++) begin
            set_all(18'($urandom), 18'($urandom));
            @(negedge clock);
            check("hold_ready", {31'd0, dataReady}, 32'd1);
            check("hold_result", {14'd0, result}, 32'h00271);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
